// File: rtl/error_heatmap_pkg.sv
// Shared constants and helpers for the error heatmap aggregator.
package error_heatmap_pkg;

    // Readout word selectors seen by the host debug bridge.
    localparam logic [1:0] WORD_READS  = 2'd0;
    localparam logic [1:0] WORD_ERRORS = 2'd1;
    localparam logic [1:0] WORD_MASK   = 2'd2;
    localparam logic [1:0] WORD_FIRST  = 2'd3;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/error_heatmap_if.sv
// Request/acknowledge readout channel between the host debug bridge and the aggregator.
interface error_heatmap_if;

    logic        rq_req;
    logic [3:0]  rq_port;
    logic [1:0]  rq_word;
    logic        rq_ack;
    logic [31:0] rq_d;

    modport master (output rq_req, rq_port, rq_word, input rq_ack, rq_d);
    modport slave  (input rq_req, rq_port, rq_word, output rq_ack, rq_d);

endinterface

// File: rtl/error_heatmap_port_stats.sv
// Statistics for one port under test: saturating counters, cumulative error
// mask and one decaying heat cell per error bit.
module port_stats
    import error_heatmap_pkg::*;
#(
    parameter int DW    = 16,
    parameter int HW    = 8,
    parameter int CW    = 32,
    parameter int DECAY = 1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             rd_stb,
    input  logic             err,
    input  logic [DW-1:0]    errbits,
    input  logic             decay_stb,
    output logic [CW-1:0]    readcount,
    output logic [CW-1:0]    errorcount,
    output logic [DW-1:0]    mask,
    output logic [DW*HW-1:0] heat
);

    localparam logic [HW-1:0] HEAT_MAX = '1;

    logic [HW-1:0] heat_q [DW];

    // Counters saturate independently; clear takes precedence over any pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readcount  <= '0;
            errorcount <= '0;
            mask       <= '0;
        end else if (clear) begin
            readcount  <= '0;
            errorcount <= '0;
            mask       <= '0;
        end else begin
            if (rd_stb)
                readcount <= CW'(sat_inc(32'(readcount), CW));
            if (err) begin
                errorcount <= CW'(sat_inc(32'(errorcount), CW));
                mask       <= mask | errbits;
            end
        end
    end

    // Heat cells: a fresh error pins a cell to max, which wins over decay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < DW; b++)
                heat_q[b] <= '0;
        end else if (clear) begin
            for (int b = 0; b < DW; b++)
                heat_q[b] <= '0;
        end else begin
            for (int b = 0; b < DW; b++) begin
                if (err && errbits[b])
                    heat_q[b] <= HEAT_MAX;
                else if (decay_stb)
                    heat_q[b] <= (int'(heat_q[b]) > DECAY) ? heat_q[b] - HW'(DECAY) : '0;
            end
        end
    end

    for (genvar b = 0; b < DW; b++) begin : g_heat_flat
        assign heat[b*HW +: HW] = heat_q[b];
    end

endmodule

// File: rtl/error_heatmap.sv
// Error-statistics aggregator for the SDRAM stress test: per-port stats,
// first-failure capture, host readout and a registered heatmap read port.
module error_heatmap
    import error_heatmap_pkg::*;
#(
    parameter  int PORTS = 5,
    parameter  int DW    = 16,
    parameter  int HW    = 8,
    parameter  int CW    = 32,
    parameter  int DECAY = 1,
    localparam int CELLS = PORTS * DW,
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PORTS-1:0]    rd_stb,
    input  logic [PORTS-1:0]    err,
    input  logic [PORTS*DW-1:0] errbits,
    input  logic                clear,
    input  logic                decay_stb,
    input  logic [AW-1:0]       hm_addr,
    output logic [HW-1:0]       hm_q,
    error_heatmap_if.slave      rq,
    output logic                any_err,
    output logic                first_valid
);

    logic [CW-1:0]       readcount  [PORTS];
    logic [CW-1:0]       errorcount [PORTS];
    logic [DW-1:0]       mask       [PORTS];
    logic [CELLS*HW-1:0] heat_flat;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        port_stats #(
            .DW    (DW),
            .HW    (HW),
            .CW    (CW),
            .DECAY (DECAY)
        ) u_stats (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .rd_stb     (rd_stb[p]),
            .err        (err[p]),
            .errbits    (errbits[p*DW +: DW]),
            .decay_stb  (decay_stb),
            .readcount  (readcount[p]),
            .errorcount (errorcount[p]),
            .mask       (mask[p]),
            .heat       (heat_flat[p*DW*HW +: DW*HW])
        );
    end

    logic [3:0]  low_idx;
    logic [15:0] low_bits;
    logic        any_next;
    logic [3:0]  first_port;
    logic [15:0] first_bits;

    // Lowest erroring port this cycle, and whether any mask is or is about to become nonzero.
    always_comb begin
        low_idx  = '0;
        any_next = 1'b0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (err[p])
                low_idx = 4'(p);
        end
        for (int p = 0; p < PORTS; p++) begin
            any_next = any_next | (|mask[p]) | (err[p] & (|errbits[p*DW +: DW]));
        end
        low_bits = 16'(errbits[int'(low_idx)*DW +: DW]);
    end

    // First-failure capture freezes after the first erroring cycle until clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_valid <= 1'b0;
            first_port  <= '0;
            first_bits  <= '0;
        end else if (clear) begin
            first_valid <= 1'b0;
            first_port  <= '0;
            first_bits  <= '0;
        end else if (!first_valid && (|err)) begin
            first_valid <= 1'b1;
            first_port  <= low_idx;
            first_bits  <= low_bits;
        end
    end

    // any_err tracks the masks with the same one-cycle latency as the masks themselves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            any_err <= 1'b0;
        else if (clear)
            any_err <= 1'b0;
        else
            any_err <= any_next;
    end

    logic [31:0] sel_reads;
    logic [31:0] sel_errors;
    logic [31:0] sel_mask;
    logic [31:0] word_sel;

    // Readout mux; unknown ports read as zero while the first-capture word is global.
    always_comb begin
        sel_reads  = '0;
        sel_errors = '0;
        sel_mask   = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (rq.rq_port == 4'(p)) begin
                sel_reads  = 32'(readcount[p]);
                sel_errors = 32'(errorcount[p]);
                sel_mask   = 32'(mask[p]);
            end
        end
        case (rq.rq_word)
            WORD_READS:  word_sel = sel_reads;
            WORD_ERRORS: word_sel = sel_errors;
            WORD_MASK:   word_sel = sel_mask;
            WORD_FIRST:  word_sel = {first_valid, 11'b0, first_port, first_bits};
            default:     word_sel = '0;
        endcase
    end

    // One ack per request, carrying the state as it was before this edge's updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq.rq_ack <= 1'b0;
            rq.rq_d   <= '0;
        end else begin
            rq.rq_ack <= rq.rq_req;
            if (rq.rq_req)
                rq.rq_d <= word_sel;
        end
    end

    logic [HW-1:0] hm_sel;

    // Heat cell lookup; addresses past the last cell read as zero.
    always_comb begin
        hm_sel = '0;
        if (int'(hm_addr) < CELLS)
            hm_sel = heat_flat[int'(hm_addr)*HW +: HW];
    end

    // Registered heat read port for the video renderer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hm_q <= '0;
        else
            hm_q <= hm_sel;
    end

endmodule

// File: tb/tb_error_heatmap.sv
// Self-checking bench for error_heatmap: readout results go through a scoreboard
// queue and are compared whenever the DUT acknowledges.
module tb_error_heatmap;
    import error_heatmap_pkg::*;

    localparam int PORTS = 5;
    localparam int DW    = 16;
    localparam int HW    = 8;
    localparam int CW    = 4;
    localparam int DECAY = 1;
    localparam int AW    = $clog2(PORTS * DW);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [PORTS-1:0]    rd_stb = '0;
    logic [PORTS-1:0]    err = '0;
    logic [PORTS*DW-1:0] errbits = '0;
    logic                clear = 1'b0;
    logic                decay_stb = 1'b0;
    logic [AW-1:0]       hm_addr = '0;
    logic [HW-1:0]       hm_q;
    logic                any_err;
    logic                first_valid;

    error_heatmap_if rq_if ();

    error_heatmap #(
        .PORTS (PORTS),
        .DW    (DW),
        .HW    (HW),
        .CW    (CW),
        .DECAY (DECAY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_stb      (rd_stb),
        .err         (err),
        .errbits     (errbits),
        .clear       (clear),
        .decay_stb   (decay_stb),
        .hm_addr     (hm_addr),
        .hm_q        (hm_q),
        .rq          (rq_if),
        .any_err     (any_err),
        .first_valid (first_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  port;
        logic [1:0]  word;
        logic [31:0] exp;
    } rq_vec_t;

    rq_vec_t sb[$];
    rq_vec_t vecs[$];
    int      checks = 0;
    int      fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [PORTS*DW-1:0] portBits(input int p, input logic [DW-1:0] b);
        logic [PORTS*DW-1:0] v;
        v = '0;
        v[p*DW +: DW] = b;
        return v;
    endfunction

    task automatic applyStimulus(input logic [PORTS-1:0] rd, input logic [PORTS-1:0] e,
                                 input logic [PORTS*DW-1:0] bits, input logic clr, input logic dec);
        @(negedge clk);
        rd_stb    = rd;
        err       = e;
        errbits   = bits;
        clear     = clr;
        decay_stb = dec;
        @(negedge clk);
        rd_stb    = '0;
        err       = '0;
        errbits   = '0;
        clear     = 1'b0;
        decay_stb = 1'b0;
    endtask

    task automatic addVec(input int port, input int word, input logic [31:0] exp);
        rq_vec_t v;
        v.port = 4'(port);
        v.word = 2'(word);
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    // Issue every queued vector as back-to-back requests, then let the acks drain.
    task automatic runTable();
        foreach (vecs[i]) begin
            @(negedge clk);
            rq_if.rq_req  = 1'b1;
            rq_if.rq_port = vecs[i].port;
            rq_if.rq_word = vecs[i].word;
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        rq_if.rq_req = 1'b0;
        repeat (2) @(negedge clk);
        vecs.delete();
    endtask

    task automatic readHeat(input int addr, input logic [HW-1:0] exp);
        @(negedge clk);
        hm_addr = AW'(addr);
        @(negedge clk);
        checkOutput($sformatf("hm_q[%0d]", addr), 32'(hm_q), 32'(exp));
    endtask

    // Scoreboard consumer: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        rq_vec_t v;
        if (!reset && rq_if.rq_ack) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_ack: got ack with rq_d 0x%0h, expected no ack", rq_if.rq_d);
            end else begin
                v = sb.pop_front();
                checkOutput($sformatf("rq p%0d w%0d", v.port, v.word), rq_if.rq_d, v.exp);
            end
        end
    end

    initial begin
        rq_if.rq_req  = 1'b0;
        rq_if.rq_port = '0;
        rq_if.rq_word = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset rq_ack", 32'(rq_if.rq_ack), 0);
        checkOutput("reset rq_d", rq_if.rq_d, 0);
        checkOutput("reset hm_q", 32'(hm_q), 0);
        checkOutput("reset any_err", 32'(any_err), 0);
        checkOutput("reset first_valid", 32'(first_valid), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single error on port 2
        applyStimulus('0, 5'b00100, portBits(2, 16'h0005), 1'b0, 1'b0);
        checkOutput("any_err after err2", 32'(any_err), 1);
        checkOutput("first_valid after err2", 32'(first_valid), 1);
        addVec(2, 1, 32'h1);
        addVec(2, 2, 32'h5);
        addVec(0, 1, 32'h0);
        addVec(2, 3, 32'h8002_0005);
        runTable();
        readHeat(32, 8'hFF);
        readHeat(33, 8'h00);
        readHeat(34, 8'hFF);

        // Decay, then long decay with floor at zero
        repeat (3) applyStimulus('0, '0, '0, 1'b0, 1'b1);
        readHeat(32, 8'hFC);
        readHeat(34, 8'hFC);
        for (int i = 0; i < 300; i++) applyStimulus('0, '0, '0, 1'b0, 1'b1);
        readHeat(32, 8'h00);
        readHeat(34, 8'h00);

        // Simultaneous errors pick the lowest port; later errors leave the capture alone
        applyStimulus('0, '0, '0, 1'b1, 1'b0);
        checkOutput("first_valid after clear", 32'(first_valid), 0);
        checkOutput("any_err after clear", 32'(any_err), 0);
        applyStimulus('0, 5'b01010, portBits(1, 16'h00A0) | portBits(3, 16'h0100), 1'b0, 1'b0);
        applyStimulus('0, 5'b00001, portBits(0, 16'h0001), 1'b0, 1'b0);
        addVec(0, 3, 32'h8001_00A0);
        addVec(3, 2, 32'h0100);
        addVec(0, 2, 32'h0001);
        addVec(1, 1, 32'h1);
        addVec(2, 1, 32'h0);
        runTable();
        readHeat(21, 8'hFF);

        // Saturation with simultaneous read and zero-bit error pulses
        for (int i = 0; i < 20; i++) applyStimulus(5'b00001, 5'b00100, '0, 1'b0, 1'b0);
        addVec(0, 0, 32'hF);
        addVec(2, 1, 32'hF);
        addVec(2, 2, 32'h0);
        addVec(2, 0, 32'h0);
        runTable();

        // Clear wins over a same-cycle error
        applyStimulus('0, 5'b00001, portBits(0, 16'hFFFF), 1'b1, 1'b0);
        checkOutput("first_valid clear vs err", 32'(first_valid), 0);
        checkOutput("any_err clear vs err", 32'(any_err), 0);
        addVec(0, 0, 32'h0);
        addVec(0, 1, 32'h0);
        addVec(0, 2, 32'h0);
        addVec(2, 1, 32'h0);
        addVec(0, 3, 32'h0);
        runTable();
        readHeat(0, 8'h00);
        readHeat(21, 8'h00);

        // Set beats decay on the same cell; neighbour still decays
        applyStimulus('0, 5'b10000, portBits(4, 16'h0002), 1'b0, 1'b0);
        applyStimulus('0, 5'b10000, portBits(4, 16'h0001), 1'b0, 1'b1);
        readHeat(64, 8'hFF);
        readHeat(65, 8'hFE);
        readHeat(80, 8'h00);
        addVec(4, 2, 32'h3);
        addVec(4, 1, 32'h2);
        addVec(7, 0, 32'h0);
        addVec(5, 2, 32'h0);
        addVec(9, 3, 32'h8004_0002);
        runTable();

        // A request in the same cycle as an update sees the old value
        @(negedge clk);
        rq_if.rq_req  = 1'b1;
        rq_if.rq_port = 4'd3;
        rq_if.rq_word = WORD_ERRORS;
        err           = 5'b01000;
        sb.push_back('{port: 4'd3, word: 2'd1, exp: 32'h0});
        @(negedge clk);
        err = '0;
        sb.push_back('{port: 4'd3, word: 2'd1, exp: 32'h1});
        @(negedge clk);
        rq_if.rq_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during a pending ack drops it asynchronously
        @(negedge clk);
        rq_if.rq_req  = 1'b1;
        rq_if.rq_port = 4'd4;
        rq_if.rq_word = WORD_MASK;
        @(posedge clk);
        #1;
        checkOutput("ack before reset", 32'(rq_if.rq_ack), 1);
        #1;
        reset        = 1'b1;
        rq_if.rq_req = 1'b0;
        #1;
        checkOutput("ack after async reset", 32'(rq_if.rq_ack), 0);
        checkOutput("any_err after async reset", 32'(any_err), 0);
        checkOutput("first_valid after async reset", 32'(first_valid), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("scoreboard drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/error_heatmap.md
# error_heatmap

Parametrised error-statistics aggregator for the SDRAM stress-test top level. It collects per-port error pulses, error-bit vectors and read-completion pulses from PORTS port testers. It maintains per-port saturating read and error counters, cumulative error masks, first-failure capture and a decaying per-bit heatmap. A single request/acknowledge readout serves the host debug bridge, and a separate 1-cycle-latency read port serves the video heatmap renderer.

## Interface
- PORTS, 5, number of ports under test (1..16)
- DW, 16, error-bit vector width per port
- HW, 8, heat value width; max heat = 2^HW-1
- CW, 32, counter width (≤32)
- DECAY, 1, heat decrement per decay strobe (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_stb  in  PORTS  per-port read-completed pulse
- err  in  PORTS  per-port error pulse
- errbits  in  PORTS*DW  flattened error vectors; port p at [p*DW +: DW], valid when err[p]
- clear  in  1  synchronous clear of all statistics
- decay_stb  in  1  heat decay strobe (one per frame)
- hm_addr  in  $clog2(PORTS*DW)  heat cell index = port*DW+bit
- hm_q  out  HW  heat value of hm_addr, registered
- rq_req  in  1  readout request pulse
- rq_port  in  4  port select
- rq_word  in  2  word select
- rq_ack  out  1  readout acknowledge pulse
- rq_d  out  32  readout data, valid while rq_ack
- any_err  out  1  OR of all cumulative masks
- first_valid  out  1  a first error has been captured

## Operation
- readcount[p] increments on rd_stb[p]; errorcount[p] increments on err[p]. Both saturate at 2^CW-1 and never wrap. Both may increment in the same cycle.
- On err[p], mask[p] |= errbits[p]. For each set bit b, heat[p*DW+b] is set to max.
- err with all-zero errbits increments errorcount only.
- On decay_stb, every heat cell not being set this cycle decrements by DECAY, flooring at 0.
- Set beats decay on the same cell in the same cycle.
- First capture: on the first cycle after reset/clear in which any err is high, latch first_port (lowest asserted index), first_bits and first_valid=1. Later errors do not update the capture.
- clear zeroes all counters, masks, heat, the first capture and any_err. clear beats err, rd_stb and decay_stb in the same cycle.
- Readout words, zero-extended to 32 bits:
  - 0 = readcount
  - 1 = errorcount
  - 2 = mask
  - 3 = {first_valid, 11'b0, first_port[3:0], first_bits[15:0]}. first_bits is truncated or zero-padded to 16.
- rq_port ≥ PORTS returns 0 for words 0–2. Word 3 is global and ignores rq_port.

## Timing
- All outputs are reset to 0: hm_q, rq_ack, rq_d, any_err, first_valid. All internal state is also reset to 0.
- A stat updates 1 cycle after the input pulse. Updated state is visible to readout requests issued in the following cycle.
- Readout: rq_req sampled at edge N gives rq_ack=1 and rq_d at edge N+1, reflecting state before edge N's updates.
  - rq_ack is high for exactly 1 cycle per request.
  - Back-to-back requests produce back-to-back acks. No request is ever dropped.
- hm_q reflects the hm_addr sampled at the previous edge, with heat state prior to that edge's update.
- hm_addr ≥ PORTS*DW returns 0.
- Reset asserted mid-readout clears rq_ack immediately and asynchronously; the pending ack is lost.
- any_err is registered and follows mask updates with the same 1-cycle latency.

## Structure
- Package error_heatmap_pkg holds:
  - word-select constants WORD_READS=0, WORD_ERRORS=1, WORD_MASK=2, WORD_FIRST=3
  - a saturating-increment function parametrised by width
- Sub-module port_stats: per-port counters, mask and DW heat cells, with decay/set priority. Instantiate it PORTS times via generate. The top level holds first capture, readout mux and hm_q mux.

## Test plan
- Reset, then err[2] with errbits=0x0005 -> read port 2 word1=1, word2=0x5; hm cells 32 and 34 = 0xFF; first_valid=1, word3=0x8002_0005.
- Set cell 32 to 0xFF, then 3 decay_stb with DECAY=1 -> hm_q(32)=0xFC. Then 300 decay_stb -> 0, no underflow.
- err[1] and err[3] in the same cycle, then err[0] later -> first_port=1, and the first capture is unchanged by err[0].
- With CW=4: 20 rd_stb on port 0 -> word0=0xF. clear in the same cycle as err[0] -> all words 0, first_valid=0.
- err[4] with bit 0 and decay_stb in the same cycle -> cell 64=0xFF. Also 4 consecutive rq_req -> 4 consecutive acks with correct data, including rq_port=7 -> 0.
